// File: rtl/elevator_pkg.sv
// Purpose: shared types, default parameters and width helper for the N-floor elevator controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package elevator_pkg;

    localparam int DEF_N_FLOORS      = 4;
    localparam int DEF_DOOR_CYCLES   = 10;
    localparam int DEF_TRAVEL_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE      = 2'd1,
        DOOR_OPEN = 2'd2
    } state_e;

    // Width needed to index n items; never narrower than one bit.
    function automatic int floor_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/elevator_dir_sched.sv
// Purpose: SCAN direction scheduler; classifies pending requests relative to the cabin and picks the travel direction.
// Latency: purely combinational.
// Backpressure: none.
// Ports: pending/pos/up in; req_here, req_above, req_below, next_up, go out.
module elevator_dir_sched
    import elevator_pkg::*;
#(
    parameter  int N_FLOORS = DEF_N_FLOORS,
    localparam int PW       = floor_w(N_FLOORS)
) (
    input  logic [N_FLOORS-1:0] pending,
    input  logic [PW-1:0]       pos,
    input  logic                up,
    output logic                req_here,
    output logic                req_above,
    output logic                req_below,
    output logic                next_up,
    output logic                go
);

    always_comb begin
        req_here  = 1'b0;
        req_above = 1'b0;
        req_below = 1'b0;
        for (int k = 0; k < N_FLOORS; k++) begin
            if (PW'(k) == pos) begin
                req_here = req_here | pending[k];
            end else if (PW'(k) > pos) begin
                req_above = req_above | pending[k];
            end else begin
                req_below = req_below | pending[k];
            end
        end
    end

    // Keep heading the same way while work remains there; otherwise turn
    // around if the other side has work; with no work at all, hold.
    always_comb begin
        if (up) begin
            next_up = req_above | ~req_below;
        end else begin
            next_up = req_above & ~req_below;
        end
    end

    // Only leave the floor when nobody is waiting here; the door wins.
    assign go = ~req_here & (req_above | req_below);

endmodule

// File: rtl/elevator_nfloor_fsm.sv
// Purpose: N-floor elevator controller; latches floor calls and serves them in SCAN order with travel and door-dwell timing.
// Latency: a call at the cabin floor opens the door one edge after it is latched; TRAVEL_CYCLES edges per floor.
// Backpressure: none; call_i is sampled every edge and held in the pending register until served.
// Ports: clk_i, rst_ni, call_i in; open_o, floor_o, pos_o, up_o, moving_o, pending_o out.
module elevator_nfloor_fsm
    import elevator_pkg::*;
#(
    parameter  int N_FLOORS      = DEF_N_FLOORS,
    parameter  int DOOR_CYCLES   = DEF_DOOR_CYCLES,
    parameter  int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    localparam int PW            = floor_w(N_FLOORS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_FLOORS-1:0] call_i,
    output logic                open_o,
    output logic [N_FLOORS-1:0] floor_o,
    output logic [PW-1:0]       pos_o,
    output logic                up_o,
    output logic                moving_o,
    output logic [N_FLOORS-1:0] pending_o
);

    // One shared down-counter serves both travel and dwell; it only ever
    // needs to hold the larger of the two reload values.
    localparam int TMAX = (DOOR_CYCLES > TRAVEL_CYCLES) ? DOOR_CYCLES : TRAVEL_CYCLES;
    localparam int TW   = floor_w(TMAX);

    localparam logic [TW-1:0]       DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [TW-1:0]       TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [N_FLOORS-1:0] ONE_HOT0    = N_FLOORS'(1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_MOVE = MOVE;
    localparam logic [1:0] S_DOOR = DOOR_OPEN;

    logic [1:0]          rst_sync_q;
    logic                core_rst_n;

    logic [1:0]          state_q, state_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic                up_q, up_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [N_FLOORS-1:0] pend_q, pend_d;

    logic                req_here, req_above, req_below, next_up, go;
    logic [PW-1:0]       pos_step;
    logic [N_FLOORS-1:0] here_oh, step_oh;

    // Reset asserts immediately but is released only after two edges so
    // every state flop leaves reset on the same clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign core_rst_n = rst_sync_q[1];

    elevator_dir_sched #(
        .N_FLOORS (N_FLOORS)
    ) u_sched (
        .pending   (pend_q),
        .pos       (pos_q),
        .up        (up_q),
        .req_here  (req_here),
        .req_above (req_above),
        .req_below (req_below),
        .next_up   (next_up),
        .go        (go)
    );

    // The scheduler never requests a step past either end, so the wrap of
    // this add/subtract is never taken.
    assign pos_step = up_q ? (pos_q + PW'(1)) : (pos_q - PW'(1));
    assign here_oh  = ONE_HOT0 << pos_q;
    assign step_oh  = ONE_HOT0 << pos_step;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        up_d    = up_q;
        tmr_d   = tmr_q;

        // A same-floor call while the door is open only stretches the dwell;
        // it must not leave a stale request behind.
        if (state_q == S_DOOR) begin
            pend_d = pend_q | (call_i & ~here_oh);
        end else begin
            pend_d = pend_q | call_i;
        end

        case (state_q)
            S_IDLE: begin
                if (req_here) begin
                    state_d = S_DOOR;
                    tmr_d   = DOOR_LOAD;
                    pend_d  = pend_d & ~here_oh;
                end else if (go) begin
                    state_d = S_MOVE;
                    up_d    = next_up;
                    tmr_d   = TRAVEL_LOAD;
                end
            end
            S_MOVE: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TW'(1);
                end else begin
                    // Arrival: stop only if this floor was already requested,
                    // otherwise pass through via one IDLE cycle.
                    pos_d = pos_step;
                    if (|(pend_q & step_oh)) begin
                        state_d = S_DOOR;
                        tmr_d   = DOOR_LOAD;
                        pend_d  = pend_d & ~step_oh;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DOOR: begin
                if (|(call_i & here_oh)) begin
                    tmr_d = DOOR_LOAD;
                end else if (tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            up_q    <= 1'b1;
            tmr_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            up_q    <= up_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
        end
    end

    assign open_o    = (state_q == S_DOOR);
    assign moving_o  = (state_q == S_MOVE);
    assign floor_o   = moving_o ? '0 : here_oh;
    assign pos_o     = pos_q;
    assign up_o      = up_q;
    assign pending_o = pend_q;

endmodule

// File: doc/elevator_nfloor_fsm.md
Name: elevator_nfloor_fsm

Overview:
Parametrised elevator controller for N floors, generalising the two-floor elevator FSM.
- Latches floor calls into a pending-request register and serves them in collective (SCAN) order.
- Models per-floor travel time and door dwell time.
- Exposes position, direction and status outputs that an SVA checker binds to.

Parameters:
N_FLOORS, 4, number of floors (>=2); floors numbered 0..N_FLOORS-1
DOOR_CYCLES, 10, cycles the door stays open after opening or after the last same-floor call
TRAVEL_CYCLES, 2, cycles to travel one floor (>=1)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
call_i  input  N_FLOORS  call request per floor, level or pulse, sampled every edge
open_o  output  1  door open
floor_o  output  N_FLOORS  one-hot current floor when stopped; all zero while travelling
pos_o  output  $clog2(N_FLOORS)  last reached floor, binary
up_o  output  1  current or last travel direction is up
moving_o  output  1  cabin travelling between floors
pending_o  output  N_FLOORS  latched, unserved requests

Behaviour:
- Reset (rst_ni low, asynchronous; released synchronously inside the block):
  - state IDLE, pos 0, floor_o = 1, open_o 0, up_o 1, moving_o 0, pending_o 0, timers 0.
  - Reset asserted mid-travel or with the door open returns to the reset state immediately.
- Pending register:
  - pending[k] is set at each edge where call_i[k]=1.
  - Exception: k==pos while state is DOOR_OPEN; that call is absorbed as a dwell reload.
  - pending[pos] is cleared on the edge entering DOOR_OPEN.
- IDLE state (door closed, floor_o[pos]=1):
  - pending[pos] set -> DOOR_OPEN; door timer loaded with DOOR_CYCLES-1.
  - Otherwise compute req_above = |pending above pos and req_below = |pending below pos.
  - Direction rule: keep up_o if requests exist in that direction; otherwise reverse if requests exist the other way.
  - Enter MOVE with travel timer = TRAVEL_CYCLES-1.
  - No requests: stay IDLE; up_o holds.
- MOVE state:
  - floor_o = 0, moving_o = 1, open_o = 0.
  - Timer decrements each cycle. At 0, pos is incremented (up) or decremented (down) on that edge.
  - Next state after arrival: DOOR_OPEN if pending[new pos], else IDLE.
  - A pass-through floor therefore shows floor_o for exactly 1 cycle before the next MOVE.
- DOOR_OPEN state:
  - open_o = 1, floor_o[pos] = 1.
  - Timer decrements each cycle; call_i[pos]=1 reloads it to DOOR_CYCLES-1.
  - Exit to IDLE on the edge after the timer reaches 0. The door is open exactly DOOR_CYCLES cycles after the last same-floor call.
- Invariants:
  - floor_o is one-hot0.
  - open_o implies floor_o[pos] and !moving_o.
  - pos_o stays within 0..N_FLOORS-1; the scheduler never moves past floor 0 or the top floor.
  - Calls at other floors never extend the dwell time.
- Simultaneous events:
  - A call for pos and a call for another floor arriving together: the door opens first, the other call is served afterwards.
  - Calls arriving during MOVE are latched and do not alter the current one-floor step.

Decomposition:
- Package elevator_pkg:
  - state_e {IDLE, MOVE, DOOR_OPEN}.
  - Function for floor_w width ($clog2 with minimum 1).
  - Default-parameter localparams.
- One sub-module, elevator_dir_sched:
  - Purely combinational.
  - Inputs: pending, pos, current direction.
  - Outputs: req_here, req_above, req_below, next_up, go.

Test Plan:
Default parameters (N_FLOORS=4, DOOR_CYCLES=10, TRAVEL_CYCLES=2); cycles are counted in edges.
1. Reset, then call_i[0] pulse at E0 -> DOOR_OPEN at E1; open_o high E1..E10, low at E11; floor_o=0001 throughout.
2. Idle at 0, call_i[2] pulse at E0:
   - MOVE from E1 (floor_o=0000).
   - Arrive floor 1 at E3 (floor_o=0010, 1 cycle); MOVE again E4.
   - Arrive floor 2 at E6 with open_o=1; pos_o=2, pending_o=0000.
3. Door open at floor 2, call_i[2] held high 5 cycles mid-dwell -> open_o stays high until DOOR_CYCLES cycles after the last high sample; pending_o[2] stays 0.
4. SCAN ordering: at floor 1 going up, calls 0 and 3 latched together -> serves floor 3 first (up_o=1), then reverses (up_o=0) to floor 0; no floor_o bit 0 and bit 3 simultaneously.
5. Reset asserted asynchronously mid-MOVE between floors 2 and 3 -> immediately pos_o=0, floor_o=0001, open_o=0, moving_o=0, pending_o=0000.
6. Top and bottom boundaries: at floor 3 with only pending[3], door opens and no upward move occurs; repeat at floor 0 for downward; pos_o never leaves 0..3.
